// File: rtl/tap_sum5_pkg.sv
// tapsum_pkg: shared depth, counter width, latency and sum-width helper for tap_sum5.
package tapsum_pkg;
    localparam int TAP_DEPTH = 5;
    localparam int FILL_W    = 3;
    localparam int PIPE_LAT  = 3;
    function automatic int SUM_W(input int w);
        return w + 3;
    endfunction
endpackage

// File: rtl/tap_sum5_if.sv
// tap_sum5_if: tap inputs, shift enable and windowed-sum outputs of tap_sum5.
interface tap_sum5_if
    import tapsum_pkg::*;
#(
    parameter int input_width = 37,
    parameter int out_width   = SUM_W(input_width)
) ();
    logic                          en;
    logic signed [input_width-1:0] din_stage1, din_stage2, din_stage3, din_stage4, din_stage5;
    logic signed [out_width-1:0]   dout;
    logic                          dout_valid;
    logic        [FILL_W-1:0]      fill_cnt;
    logic                          ovf;
    modport master (
        output en, din_stage1, din_stage2, din_stage3, din_stage4, din_stage5,
        input  dout, dout_valid, fill_cnt, ovf
    );
    modport slave (
        input  en, din_stage1, din_stage2, din_stage3, din_stage4, din_stage5,
        output dout, dout_valid, fill_cnt, ovf
    );
endinterface

// File: rtl/tap_sum5_add2_reg.sv
// add2_reg: registered signed adder, result one bit wider, with a tag carried alongside.
module add2_reg #(
    parameter int W  = 37,
    parameter int TW = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [TW-1:0]       i_tag,
    input  logic signed [W-1:0] i_a,
    input  logic signed [W-1:0] i_b,
    output logic [TW-1:0]       o_tag,
    output logic signed [W:0]   o_sum
);
    always_ff @(posedge clk) begin
        if (rst) begin
            o_tag <= '0;
            o_sum <= '0;
        end else begin
            o_tag <= i_tag;
            o_sum <= {i_a[W-1], i_a} + {i_b[W-1], i_b};
        end
    end
endmodule

// File: rtl/tap_sum5.sv
// tap_sum5: 3-stage pipelined signed sum of five taps, flagged valid once the window is full.
// Define TAPSUM_SAT_EN to clamp the sum to the tap range and raise ovf on clamped full results.
module tap_sum5
    import tapsum_pkg::*;
#(
    parameter int input_width = 37,
    parameter int reg_depth   = TAP_DEPTH,
    parameter int out_width   = SUM_W(input_width)
) (
    input  logic      clk,
    input  logic      rst,
    tap_sum5_if.slave bus
);
    logic                          r_shift_q;
    logic        [FILL_W-1:0]      r_fill;
    logic                          w_full;
    logic signed [input_width-1:0] r_e1, r_e2;
    logic signed [input_width:0]   w_a, w_b;
    logic signed [input_width+1:0] w_c;
    logic                          w_a_vld, w_b_full;
    logic        [1:0]             w_c_tag;
    logic signed [out_width-1:0]   w_sum, w_res;
    logic                          w_sat;
    logic signed [out_width-1:0]   r_dout;
    logic                          r_vld, r_ovf;

    // en is active low: a low en shifts the taps, so the following cycle samples them
    assign w_full = r_fill >= FILL_W'(reg_depth - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift_q <= 1'b0;
            r_fill    <= '0;
            r_e1      <= '0;
            r_e2      <= '0;
        end else begin
            r_shift_q <= ~bus.en;
            if (r_shift_q && r_fill != FILL_W'(reg_depth))
                r_fill <= r_fill + 1'b1;
            r_e1 <= bus.din_stage5;
            r_e2 <= r_e1;
        end
    end

    add2_reg #(.W(input_width), .TW(1)) u_s1a (
        .clk(clk), .rst(rst), .i_tag(r_shift_q),
        .i_a(bus.din_stage1), .i_b(bus.din_stage2), .o_tag(w_a_vld), .o_sum(w_a)
    );
    add2_reg #(.W(input_width), .TW(1)) u_s1b (
        .clk(clk), .rst(rst), .i_tag(r_shift_q && w_full),
        .i_a(bus.din_stage3), .i_b(bus.din_stage4), .o_tag(w_b_full), .o_sum(w_b)
    );
    add2_reg #(.W(input_width + 1), .TW(2)) u_s2 (
        .clk(clk), .rst(rst), .i_tag({w_b_full, w_a_vld}),
        .i_a(w_a), .i_b(w_b), .o_tag(w_c_tag), .o_sum(w_c)
    );

    assign w_sum = out_width'(w_c) + out_width'(r_e2);

`ifdef TAPSUM_SAT_EN
    localparam logic signed [out_width-1:0] SAT_MAX =
        {{(out_width - input_width + 1){1'b0}}, {(input_width - 1){1'b1}}};
    localparam logic signed [out_width-1:0] SAT_MIN = ~SAT_MAX;
    always_comb begin
        w_sat = (w_sum > SAT_MAX) || (w_sum < SAT_MIN);
        w_res = (w_sum > SAT_MAX) ? SAT_MAX : (w_sum < SAT_MIN) ? SAT_MIN : w_sum;
    end
`else
    assign w_sat = 1'b0;
    assign w_res = w_sum;
`endif

    // dout only moves when a launch leaves the pipeline; bubbles leave it holding
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
            r_vld  <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_c_tag[0])
                r_dout <= w_res;
            r_vld <= w_c_tag[0] & w_c_tag[1];
            r_ovf <= w_c_tag[0] & w_c_tag[1] & w_sat;
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_vld;
    assign bus.fill_cnt   = r_fill;
    assign bus.ovf        = r_ovf;
endmodule

// File: tb/tb_tap_sum5.sv
// tb_tap_sum5: scenario and randomized checks of tap_sum5 against a queue-based window-sum model.
module tb_tap_sum5;
    localparam longint MAXS = (longint'(1) <<< 36) - 1;
    localparam longint MINS = -(longint'(1) <<< 36);

    typedef struct {
        longint v;
        bit     full;
        int     rem;
    } item_t;

    logic   clk = 1'b0;
    logic   rst;
    int     checks = 0;
    int     errors = 0;
    item_t  q[$];
    longint m_taps[1:5] = '{default: 0};
    longint m_dout = 0;
    bit     m_vld = 0;
    bit     m_ovf = 0;
    bit     m_sq = 0;
    int     m_fill = 0;

    tap_sum5_if #(.input_width(37)) bus ();
    tap_sum5 #(.input_width(37)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    // One clock: drive en/rst, let the edge pass, advance the model, then present the
    // shift register's new tap contents.
    task automatic tick(input logic e, input logic r, input longint s);
        item_t it;
        bus.en = e;
        rst = r;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_fill = 0; m_sq = 0; m_dout = 0; m_vld = 0; m_ovf = 0;
        end else begin
            m_vld = 0;
            m_ovf = 0;
            foreach (q[i]) q[i].rem--;
            if (q.size() > 0 && q[0].rem == 0) begin
                it = q.pop_front();
                m_dout = it.v;
                m_vld = it.full;
`ifdef TAPSUM_SAT_EN
                if (it.v > MAXS) begin m_dout = MAXS; m_ovf = it.full; end
                if (it.v < MINS) begin m_dout = MINS; m_ovf = it.full; end
`endif
            end
            if (m_sq) begin
                q.push_back('{m_taps[1] + m_taps[2] + m_taps[3] + m_taps[4] + m_taps[5],
                              m_fill >= 4, 2});
                m_fill = (m_fill == 5) ? 5 : m_fill + 1;
            end
            m_sq = !e;
        end
        if (r) m_taps = '{default: 0};
        else if (!e) begin
            for (int i = 5; i > 1; i--) m_taps[i] = m_taps[i-1];
            m_taps[1] = s;
        end
        #1;
        bus.din_stage1 = 37'(m_taps[1]);
        bus.din_stage2 = 37'(m_taps[2]);
        bus.din_stage3 = 37'(m_taps[3]);
        bus.din_stage4 = 37'(m_taps[4]);
        bus.din_stage5 = 37'(m_taps[5]);
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 0);
        tick(1'b1, 1'b1, 0);
        checks++;
        if (bus.dout !== '0 || bus.dout_valid !== 1'b0 || bus.fill_cnt !== 3'd0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset: dout=%0d vld=%b fill=%0d ovf=%b, expected all 0",
                     bus.dout, bus.dout_valid, bus.fill_cnt, bus.ovf);
        end
    endtask

    task automatic test_fill();
        int nv = 0;
        for (int i = 0; i < 8; i++) begin
            tick(i >= 5, 1'b0, 1);
            nv += int'(bus.dout_valid);
            checks++;
            if (longint'(bus.dout) !== m_dout || bus.dout_valid !== m_vld ||
                bus.fill_cnt !== 3'(m_fill) || bus.ovf !== m_ovf) begin
                errors++;
                $display("FAIL fill_cyc%0d: dout=%0d vld=%b fill=%0d ovf=%b, expected %0d %b %0d %b",
                         i, bus.dout, bus.dout_valid, bus.fill_cnt, bus.ovf, m_dout, m_vld, m_fill, m_ovf);
            end
        end
        checks++;
        if (nv != 1 || bus.dout_valid !== 1'b1 || longint'(bus.dout) !== 5 || bus.fill_cnt !== 3'd5) begin
            errors++;
            $display("FAIL fill_window: pulses=%0d vld=%b dout=%0d fill=%0d, expected 1 1 5 5",
                     nv, bus.dout_valid, bus.dout, bus.fill_cnt);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 9);
            checks++;
            if (bus.dout_valid !== 1'b0 || longint'(bus.dout) !== 5 || bus.fill_cnt !== 3'd5) begin
                errors++;
                $display("FAIL hold_cyc%0d: vld=%b dout=%0d fill=%0d, expected 0 5 5",
                         i, bus.dout_valid, bus.dout, bus.fill_cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        tick(1'b1, 1'b1, 0);
        for (int i = 0; i < 13; i++) begin
            tick(i >= 10, 1'b0, (i < 5) ? -1 : longint'(i - 4));
            checks++;
            if (longint'(bus.dout) !== m_dout || bus.dout_valid !== m_vld ||
                bus.fill_cnt !== 3'(m_fill) || bus.ovf !== m_ovf) begin
                errors++;
                $display("FAIL b2b_cyc%0d: dout=%0d vld=%b fill=%0d ovf=%b, expected %0d %b %0d %b",
                         i, bus.dout, bus.dout_valid, bus.fill_cnt, bus.ovf, m_dout, m_vld, m_fill, m_ovf);
            end
            if (i >= 7) begin
                checks++;
                if (bus.dout_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_stream%0d: vld=%b, expected 1", i, bus.dout_valid);
                end
            end
        end
        checks++;
        if (longint'(bus.dout) !== 15) begin
            errors++;
            $display("FAIL b2b_last: dout=%0d, expected 15", bus.dout);
        end
    endtask

    task automatic test_negative();
        tick(1'b1, 1'b1, 0);
        for (int i = 0; i < 8; i++) tick(i >= 5, 1'b0, -1);
        checks++;
        if (longint'(bus.dout) !== -5 || bus.dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL neg_window: dout=%0d vld=%b, expected -5 1", bus.dout, bus.dout_valid);
        end
    endtask

    task automatic test_sat();
        longint hi, lo;
        logic   ov;
`ifdef TAPSUM_SAT_EN
        hi = MAXS; lo = MINS; ov = 1'b1;
`else
        hi = 5 * MAXS; lo = 5 * MINS; ov = 1'b0;
`endif
        tick(1'b1, 1'b1, 0);
        for (int i = 0; i < 8; i++) tick(i >= 5, 1'b0, MAXS);
        checks++;
        if (longint'(bus.dout) !== hi || bus.ovf !== ov || bus.dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL sat_max: dout=%0d ovf=%b vld=%b, expected %0d %b 1", bus.dout, bus.ovf, bus.dout_valid, hi, ov);
        end
        for (int i = 0; i < 8; i++) begin
            tick(i >= 5, 1'b0, MINS);
            checks++;
            if (longint'(bus.dout) !== m_dout || bus.dout_valid !== m_vld || bus.ovf !== m_ovf) begin
                errors++;
                $display("FAIL sat_cyc%0d: dout=%0d vld=%b ovf=%b, expected %0d %b %b",
                         i, bus.dout, bus.dout_valid, bus.ovf, m_dout, m_vld, m_ovf);
            end
        end
        checks++;
        if (longint'(bus.dout) !== lo || bus.ovf !== ov || bus.dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL sat_min: dout=%0d ovf=%b vld=%b, expected %0d %b 1", bus.dout, bus.ovf, bus.dout_valid, lo, ov);
        end
    endtask

    task automatic test_reset_mid();
        int nv = 0;
        tick(1'b1, 1'b1, 0);
        for (int i = 0; i < 6; i++) tick(i >= 5, 1'b0, 1);
        tick(1'b1, 1'b1, 0);
        checks++;
        if (bus.dout !== '0 || bus.dout_valid !== 1'b0 || bus.fill_cnt !== 3'd0) begin
            errors++;
            $display("FAIL rstmid_clear: dout=%0d vld=%b fill=%0d, expected 0 0 0", bus.dout, bus.dout_valid, bus.fill_cnt);
        end
        for (int i = 0; i < 11; i++) begin
            tick(!(i >= 3 && i < 7), 1'b0, 1);
            nv += int'(bus.dout_valid);
        end
        checks++;
        if (nv != 0 || bus.fill_cnt !== 3'd4) begin
            errors++;
            $display("FAIL rstmid_four: pulses=%0d fill=%0d, expected 0 4", nv, bus.fill_cnt);
        end
        tick(1'b0, 1'b0, 1);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 0);
        checks++;
        if (bus.dout_valid !== 1'b1 || longint'(bus.dout) !== 5 || bus.fill_cnt !== 3'd5) begin
            errors++;
            $display("FAIL rstmid_fifth: vld=%b dout=%0d fill=%0d, expected 1 5 5", bus.dout_valid, bus.dout, bus.fill_cnt);
        end
    endtask

    task automatic test_rst_launch();
        tick(1'b0, 1'b1, 7);
        tick(1'b1, 1'b0, 7);
        tick(1'b1, 1'b0, 7);
        checks++;
        if (bus.fill_cnt !== 3'd0 || bus.dout_valid !== 1'b0 || bus.dout !== '0) begin
            errors++;
            $display("FAIL rst_launch: fill=%0d vld=%b dout=%0d, expected 0 0 0", bus.fill_cnt, bus.dout_valid, bus.dout);
        end
    endtask

    task automatic test_random();
        longint s;
        logic signed [36:0] v;
        tick(1'b1, 1'b1, 0);
        for (int i = 0; i < 400; i++) begin
            v = 37'({$urandom(), $urandom()});
            case ($urandom_range(0, 3))
                0:       s = MAXS;
                1:       s = MINS;
                default: s = longint'(v);
            endcase
            tick($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 2, s);
            checks++;
            if (longint'(bus.dout) !== m_dout || bus.dout_valid !== m_vld ||
                bus.fill_cnt !== 3'(m_fill) || bus.ovf !== m_ovf) begin
                errors++;
                $display("FAIL rand_cyc%0d: dout=%0d vld=%b fill=%0d ovf=%b, expected %0d %b %0d %b",
                         i, bus.dout, bus.dout_valid, bus.fill_cnt, bus.ovf, m_dout, m_vld, m_fill, m_ovf);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b1;
        bus.din_stage1 = '0;
        bus.din_stage2 = '0;
        bus.din_stage3 = '0;
        bus.din_stage4 = '0;
        bus.din_stage5 = '0;
        test_reset();
        test_fill();
        test_hold();
        test_negative();
        test_back_to_back();
        test_sat();
        test_reset_mid();
        test_rst_launch();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tap_sum5.md
Name: tap_sum5

Overview:
- Consumer end of the 5-stage output shift register.
- Takes the five tap outputs plus the shift enable, and produces their signed sum through a pipelined adder tree.
- Tracks window fill, so a result is flagged valid only once all five taps hold shifted-in data.
- Feeds the downstream feature logic: the NE/LL accumulation path.

Parameters:
- input_width, 37, tap width, signed; matches the shift register instance.
- reg_depth, 5, number of taps; fixed at 5, and the fill counter saturates here.
- out_width, input_width+3, sum width; must be >= input_width+3.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  shift enable, active low; the same net that drives the shift register's en.
- din_stage1..din_stage5  in  input_width each  signed taps; stage1 is the newest sample.
- dout  out  out_width  signed windowed sum.
- dout_valid  out  1  one-cycle pulse per full-window result.
- fill_cnt  out  3  number of launches since reset, saturating at 5.
- ovf  out  1  saturation flag; tied 0 unless the macro is defined.

Behaviour:
- Reset: rst is synchronous and active-high. When rst=1 at a clk edge, all of the following clear to 0:
  - shift_q, fill_cnt, all pipeline valid/full tags, all pipeline data, dout, dout_valid, ovf.
- Launch detect: shift_q <= ~en each cycle.
  - A cycle with shift_q=1 is a launch: the taps were updated by the previous edge and are sampled this cycle.
  - en=1 (hold) produces no launch.
- Fill tracking:
  - On each launch, fill_cnt <= min(fill_cnt+1, 5).
  - The launch is tagged full if fill_cnt >= 4 at launch, i.e. the post-increment value is 5.
- Pipeline, 3 register stages, every stage sign-extends its operands:
  - S1: a = d1+d2 and b = d3+d4 (input_width+1 bits); e = d5 delayed.
  - S2: c = a+b (input_width+2 bits); e delayed again.
  - S3: dout <= sign-extend(c+e) to out_width.
- Latency and validity:
  - The launch cycle at edge N produces dout/dout_valid at edge N+3.
  - dout_valid = full tag of the result in S3; high for exactly one cycle per full launch.
  - Back-to-back launches give dout_valid every cycle; throughput is 1 per clk.
- Non-full launches still traverse the pipeline and update dout, but dout_valid stays 0.
- dout holds its value when no launch exits S3. The pipeline advances every cycle; stage valids mark bubbles.
- Simultaneous rst and a launch: rst wins and nothing is captured.
- Reset mid-operation discards in-flight results. fill must restart from 0, because the shift register also clears to zeros on the same rst.
- No arithmetic overflow is possible with out_width >= input_width+3.

Optional Feature:
- Macro: TAPSUM_SAT_EN.
- Defined:
  - S3 clamps the sum to the signed input_width range [-2^(input_width-1), 2^(input_width-1)-1], sign-extended to out_width.
  - ovf is registered alongside dout and is high for the same cycle when clamping occurred on a full result.
- Undefined: full-precision sum is output, and ovf is constant 0.

Decomposition:
- Shared package tapsum_pkg holds:
  - TAP_DEPTH = 5
  - FILL_W = 3
  - PIPE_LAT = 3
  - the width function SUM_W(w) = w+3
- Sub-module add2_reg: a registered signed adder with valid passthrough (parameterised width, output one bit wider).
  - Instanced three times in S1/S2.
  - S3 is inline because it carries the saturation.

Test Plan:
1. rst, then en=0 for 5 cycles with din=1 shifted (taps 1,1,1,1,1 at the fifth launch) -> fill_cnt reaches 5; dout=5 with dout_valid=1 exactly 3 cycles after the fifth launch, and no valid pulse earlier.
2. Full window, then en=1 for 4 cycles -> no further dout_valid; dout holds 5; fill_cnt stays 5.
3. All taps = -1 with a full window -> dout = 40'hFF_FFFF_FFFB (-5), valid pulse; a continuous en=0 stream gives valid every cycle with correct sums for taps 1,2,3,4,5 -> 15.
4. All taps = 2^36-1 -> without the macro, dout=343597383675 and ovf=0; with TAPSUM_SAT_EN, dout=68719476735 and ovf=1. All taps = -2^36 with the macro -> dout=-68719476736, ovf=1.
5. rst asserted 1 cycle after the fifth launch -> in-flight result dropped, dout=0, dout_valid=0, fill_cnt=0; the next valid needs 5 new launches.
6. rst and en=0 in the same cycle -> shift_q=0 next cycle, fill_cnt stays 0.
